id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register feeding the ALU. Captures one decoded instruction per
//  valid/ready handshake, resolves EX/MEM and MEM/WB forwarding, selects ALU operands
//  (rs1/pc, rs2/imm), detects load-use hazards, and presents registered a/b/ctrl to the ALU.
//  Consumers downstream see a stable beat until out_ready; flush kills in-flight work.
// PARAMETERS
//  XLEN      32  datapath width; ALU operands, pc, imm, forwarded data
//  REG_AW    5   register index width (32 GPRs, x0 hard-wired zero)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      reset, synchronous, active-low
//  in_valid     in   1      decode beat valid
//  in_ready     out  1      stage can accept beat this cycle
//  in_pc        in   XLEN   instruction pc
//  in_rs1_idx   in   REG_AW / in_rs2_idx in REG_AW: source indices
//  in_rs1_data  in   XLEN   / in_rs2_data in XLEN: regfile read data
//  in_imm       in   XLEN   sign-extended immediate
//  in_alu_ctrl  in   4      ALU op code (rv_pkg::alu_op_e)
//  in_a_sel     in   1      0: rs1, 1: pc
//  in_b_sel     in   1      0: rs2, 1: imm
//  in_rd_idx    in   REG_AW / in_reg_wr in 1 / in_is_load in 1: dest info, passed through
//  exm_valid    in   1      EX/MEM holds a reg-writing instr
//  exm_rd_idx   in   REG_AW / exm_data in XLEN / exm_is_load in 1: EX/MEM forward source
//  mwb_valid    in   1      MEM/WB holds a reg-writing instr
//  mwb_rd_idx   in   REG_AW / mwb_data in XLEN: MEM/WB forward source
//  flush        in   1      kill stage contents and input beat (branch taken / trap)
//  out_valid    out  1      ALU beat valid
//  out_ready    in   1      downstream accepts beat
//  alu_a        out  XLEN   / alu_b out XLEN / alu_ctrl out 4: registered ALU inputs
//  store_data   out  XLEN   forwarded rs2 value (for stores / branch compare)
//  out_pc, out_imm XLEN; out_rd_idx REG_AW; out_reg_wr 1; out_is_load 1: passthrough
//  illegal_op   out  1      registered: captured alu_ctrl > 4'b1010
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): out_valid=0, illegal_op=0, alu_a=alu_b=store_data=0,
//    alu_ctrl=4'b0000, all passthrough regs=0. Reset wins over flush and capture.
//  - hazard = exm_valid & exm_is_load & exm_rd_idx!=0 & (exm_rd_idx==rs1 & !in_a_sel |
//    exm_rd_idx==rs2) -- rs2 always counts (store_data). Combinational on in_* ports.
//  - in_ready = (!out_valid | out_ready) & !hazard. Capture iff in_valid & in_ready.
//  - Latency: 1 cycle; captured beat visible on out_* the following cycle.
//  - No capture & out_ready & out_valid -> out_valid=0 next cycle (bubble); hazard stall
//    therefore inserts exactly one bubble per load-use; data regs hold last value.
//  - out_valid & !out_ready: all out_* held stable, in_ready=0.
//  - Forwarding per source (x0 never forwarded, reads 0): EX/MEM match (non-load) first,
//    else MEM/WB match, else regfile data. EX/MEM load match never forwarded (hazard).
//  - alu_a = a_sel ? pc : fwd_rs1; alu_b = b_sel ? imm : fwd_rs2; store_data = fwd_rs2.
//  - flush=1: out_valid=0 next cycle; in_ready forced 1 so the concurrent input beat is
//    consumed and discarded; illegal_op cleared. flush during stall releases the stall.
//  - illegal_op only meaningful while out_valid; ALU op codes 4'b1011-4'b1111 flag it.
// STRUCTURE
//  - rv_pkg: XLEN, REG_AW, alu_op_e (ADD=0000..SLTU=1010), a_sel_e, b_sel_e, ALU_OP_MAX.
//  - Sub-module fwd_mux (comb, instanced twice): idx, regfile data, exm/mwb ports -> value.
//  - Top: hazard/ready logic + single always_ff register bank with sync active-low reset.
// TESTING
//  - Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, alu_ctrl=0, in_ready=1 after.
//  - Forward priority: rs1=5, exm rd=5 data=0xAAAA, mwb rd=5 data=0xBBBB -> alu_a=0xAAAA;
//    rs2=0 with exm rd=0 data=0x1234 -> store_data=0.
//  - Load-use: exm_is_load rd=7, in rs2=7 -> in_ready=0 one cycle, out_valid bubble; next
//    cycle mwb rd=7 data=0x55 -> captured alu_b=0x55 (b_sel=0).
//  - Backpressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; release -> next
//    beat captured on same edge old beat consumed (back-to-back, no bubble).
//  - Flush: flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input dropped.
//  - Operand sel/illegal: a_sel=1 pc=0x100, b_sel=1 imm=0xFFFFFFFC, ctrl=4'b1100 ->
//    alu_a=0x100, alu_b=0xFFFFFFFC, illegal_op=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV core definitions for the decode/execute boundary: widths, ALU op
// encoding, operand-select encodings and the ALU opcode legality check.
package rv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b0001,
      ALU_AND   = 4'b0010,
      ALU_OR    = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SLL   = 4'b0101,
      ALU_SRL   = 4'b0110,
      ALU_SRA   = 4'b0111,
      ALU_PASSB = 4'b1000,
      ALU_SLT   = 4'b1001,
      ALU_SLTU  = 4'b1010
   } alu_op_e;

   localparam logic [3:0] ALU_OP_MAX = 4'b1010;

   typedef enum logic {
      A_RS1 = 1'b0,
      A_PC  = 1'b1
   } a_sel_e;

   typedef enum logic {
      B_RS2 = 1'b0,
      B_IMM = 1'b1
   } b_sel_e;

   // Codes above the last defined ALU op are reserved and must be trapped.
   function automatic logic alu_op_illegal(input logic [3:0] op);
      return (op > ALU_OP_MAX);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats the
// register file; x0 always reads zero and a load in EX/MEM is never a source.
module fwd_mux #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] idx,
   input  logic [XLEN-1:0]   rf_data,
   input  logic              exm_valid,
   input  logic [REG_AW-1:0] exm_rd_idx,
   input  logic [XLEN-1:0]   exm_data,
   input  logic              exm_is_load,
   input  logic              mwb_valid,
   input  logic [REG_AW-1:0] mwb_rd_idx,
   input  logic [XLEN-1:0]   mwb_data,
   output logic [XLEN-1:0]   value
);

   logic exm_hit_s;
   logic mwb_hit_s;

   assign exm_hit_s = exm_valid & ~exm_is_load & (exm_rd_idx == idx);
   assign mwb_hit_s = mwb_valid & (mwb_rd_idx == idx);

   // Priority select of the youngest producer of this register.
   always_comb begin
      value = '0;
      if (idx == '0) begin
         value = '0;
      end else if (exm_hit_s) begin
         value = exm_data;
      end else if (mwb_hit_s) begin
         value = mwb_data;
      end else begin
         value = rf_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register: forwarding, operand select, load-use
// stall and a registered, backpressure-aware beat toward the ALU.
module id_ex_stage #(
   parameter int XLEN   = rv_pkg::XLEN,
   parameter int REG_AW = rv_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [REG_AW-1:0] in_rs1_idx,
   input  logic [REG_AW-1:0] in_rs2_idx,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [3:0]        in_alu_ctrl,
   input  logic              in_a_sel,
   input  logic              in_b_sel,
   input  logic [REG_AW-1:0] in_rd_idx,
   input  logic              in_reg_wr,
   input  logic              in_is_load,
   input  logic              exm_valid,
   input  logic [REG_AW-1:0] exm_rd_idx,
   input  logic [XLEN-1:0]   exm_data,
   input  logic              exm_is_load,
   input  logic              mwb_valid,
   input  logic [REG_AW-1:0] mwb_rd_idx,
   input  logic [XLEN-1:0]   mwb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [3:0]        alu_ctrl,
   output logic [XLEN-1:0]   store_data,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_imm,
   output logic [REG_AW-1:0] out_rd_idx,
   output logic              out_reg_wr,
   output logic              out_is_load,
   output logic              illegal_op
);

   import rv_pkg::*;

   logic              hazard_s;
   logic              ready_s;
   logic              capture_s;
   logic [XLEN-1:0]   fwd_rs1_s;
   logic [XLEN-1:0]   fwd_rs2_s;
   logic [XLEN-1:0]   opa_s;
   logic [XLEN-1:0]   opb_s;

   logic              out_valid_r;
   logic [XLEN-1:0]   alu_a_r;
   logic [XLEN-1:0]   alu_b_r;
   logic [3:0]        alu_ctrl_r;
   logic [XLEN-1:0]   store_data_r;
   logic [XLEN-1:0]   pc_r;
   logic [XLEN-1:0]   imm_r;
   logic [REG_AW-1:0] rd_idx_r;
   logic              reg_wr_r;
   logic              is_load_r;
   logic              illegal_r;

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .idx         (in_rs1_idx),
      .rf_data     (in_rs1_data),
      .exm_valid   (exm_valid),
      .exm_rd_idx  (exm_rd_idx),
      .exm_data    (exm_data),
      .exm_is_load (exm_is_load),
      .mwb_valid   (mwb_valid),
      .mwb_rd_idx  (mwb_rd_idx),
      .mwb_data    (mwb_data),
      .value       (fwd_rs1_s)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .idx         (in_rs2_idx),
      .rf_data     (in_rs2_data),
      .exm_valid   (exm_valid),
      .exm_rd_idx  (exm_rd_idx),
      .exm_data    (exm_data),
      .exm_is_load (exm_is_load),
      .mwb_valid   (mwb_valid),
      .mwb_rd_idx  (mwb_rd_idx),
      .mwb_data    (mwb_data),
      .value       (fwd_rs2_s)
   );

   // Load-use: rs1 only matters when it feeds the ALU; rs2 always does (store data).
   assign hazard_s = exm_valid & exm_is_load & (exm_rd_idx != '0) &
                     (((exm_rd_idx == in_rs1_idx) & (in_a_sel == A_RS1)) |
                      (exm_rd_idx == in_rs2_idx));

   // Flush forces acceptance so the concurrent beat is swallowed, not stalled.
   assign ready_s   = flush | ((~out_valid_r | out_ready) & ~hazard_s);
   assign capture_s = in_valid & ready_s & ~flush;

   // ALU operand selection from forwarded sources, pc and immediate.
   always_comb begin
      opa_s = '0;
      opb_s = '0;
      if (in_a_sel == A_PC) begin
         opa_s = in_pc;
      end else begin
         opa_s = fwd_rs1_s;
      end
      if (in_b_sel == B_IMM) begin
         opb_s = in_imm;
      end else begin
         opb_s = fwd_rs2_s;
      end
   end

   // Stage register bank: reset, then flush, then capture, then drain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         alu_a_r      <= '0;
         alu_b_r      <= '0;
         alu_ctrl_r   <= 4'b0000;
         store_data_r <= '0;
         pc_r         <= '0;
         imm_r        <= '0;
         rd_idx_r     <= '0;
         reg_wr_r     <= 1'b0;
         is_load_r    <= 1'b0;
         illegal_r    <= 1'b0;
      end else if (flush) begin
         out_valid_r  <= 1'b0;
         illegal_r    <= 1'b0;
      end else if (capture_s) begin
         out_valid_r  <= 1'b1;
         alu_a_r      <= opa_s;
         alu_b_r      <= opb_s;
         alu_ctrl_r   <= in_alu_ctrl;
         store_data_r <= fwd_rs2_s;
         pc_r         <= in_pc;
         imm_r        <= in_imm;
         rd_idx_r     <= in_rd_idx;
         reg_wr_r     <= in_reg_wr;
         is_load_r    <= in_is_load;
         illegal_r    <= alu_op_illegal(in_alu_ctrl);
      end else if (out_ready) begin
         out_valid_r  <= 1'b0;
      end else begin
         out_valid_r  <= out_valid_r;
      end
   end

   assign in_ready    = ready_s;
   assign out_valid   = out_valid_r;
   assign alu_a       = alu_a_r;
   assign alu_b       = alu_b_r;
   assign alu_ctrl    = alu_ctrl_r;
   assign store_data  = store_data_r;
   assign out_pc      = pc_r;
   assign out_imm     = imm_r;
   assign out_rd_idx  = rd_idx_r;
   assign out_reg_wr  = reg_wr_r;
   assign out_is_load = is_load_r;
   assign illegal_op  = illegal_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a stimulus process queues hand-computed
// beats, a monitor pops and compares them on every output handshake.
module tb_id_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1_idx;
   logic [4:0]  in_rs2_idx;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [31:0] in_imm;
   logic [3:0]  in_alu_ctrl;
   logic        in_a_sel;
   logic        in_b_sel;
   logic [4:0]  in_rd_idx;
   logic        in_reg_wr;
   logic        in_is_load;
   logic        exm_valid;
   logic [4:0]  exm_rd_idx;
   logic [31:0] exm_data;
   logic        exm_is_load;
   logic        mwb_valid;
   logic [4:0]  mwb_rd_idx;
   logic [31:0] mwb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] store_data;
   logic [31:0] out_pc;
   logic [31:0] out_imm;
   logic [4:0]  out_rd_idx;
   logic        out_reg_wr;
   logic        out_is_load;
   logic        illegal_op;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] st;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        wr;
      logic        ld;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_alu_ctrl(in_alu_ctrl), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
      .in_rd_idx(in_rd_idx), .in_reg_wr(in_reg_wr), .in_is_load(in_is_load),
      .exm_valid(exm_valid), .exm_rd_idx(exm_rd_idx), .exm_data(exm_data),
      .exm_is_load(exm_is_load), .mwb_valid(mwb_valid), .mwb_rd_idx(mwb_rd_idx),
      .mwb_data(mwb_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .store_data(store_data), .out_pc(out_pc), .out_imm(out_imm),
      .out_rd_idx(out_rd_idx), .out_reg_wr(out_reg_wr),
      .out_is_load(out_is_load), .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every accepted output beat must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t act;
      exp_t exp;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         act = '{alu_a, alu_b, store_data, out_pc, out_imm, alu_ctrl,
                 out_rd_idx, out_reg_wr, out_is_load, illegal_op};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected: got %h expected no beat", act);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               failures++;
               $display("FAIL beat: got %h expected %h", act, exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] ctrl, input logic asel,
                        input logic bsel, input logic [4:0] rd, input logic wr,
                        input logic ld);
      in_valid    = v;
      in_pc       = pc;
      in_rs1_idx  = rs1;
      in_rs1_data = d1;
      in_rs2_idx  = rs2;
      in_rs2_data = d2;
      in_imm      = imm;
      in_alu_ctrl = ctrl;
      in_a_sel    = asel;
      in_b_sel    = bsel;
      in_rd_idx   = rd;
      in_reg_wr   = wr;
      in_is_load  = ld;
   endtask

   task automatic set_exm(input logic v, input logic [4:0] rd, input logic [31:0] d,
                          input logic ld);
      exm_valid   = v;
      exm_rd_idx  = rd;
      exm_data    = d;
      exm_is_load = ld;
   endtask

   task automatic set_mwb(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mwb_valid  = v;
      mwb_rd_idx = rd;
      mwb_data   = d;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      set_exm(1'b0, 5'd0, 32'h0, 1'b0);
      set_mwb(1'b0, 5'd0, 32'h0);
      drive(1'b1, 32'h1000, 5'd1, 32'h11, 5'd2, 32'h22, 32'h4, 4'b0011,
            1'b0, 1'b0, 5'd3, 1'b1, 1'b0);

      // Reset held two cycles with a valid beat on the input
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_store_data", store_data, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Forwarding: EX/MEM wins over MEM/WB
      tick();
      set_exm(1'b1, 5'd5, 32'hAAAA, 1'b0);
      set_mwb(1'b1, 5'd5, 32'hBBBB);
      drive(1'b1, 32'h40, 5'd5, 32'h1111, 5'd9, 32'h9999, 32'h4, 4'b0000,
            1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      #1;
      chk("fwdA_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back('{32'hAAAA, 32'h9999, 32'h9999, 32'h40, 32'h4, 4'b0000, 5'd3, 1'b1, 1'b0, 1'b0});
      tick();
      // x0 is never forwarded and reads zero
      set_exm(1'b1, 5'd0, 32'h1234, 1'b0);
      set_mwb(1'b1, 5'd0, 32'h4321);
      drive(1'b1, 32'h44, 5'd6, 32'h66, 5'd0, 32'h7777, 32'h8, 4'b0001,
            1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
      exp_q.push_back('{32'h66, 32'h0, 32'h0, 32'h44, 32'h8, 4'b0001, 5'd4, 1'b1, 1'b0, 1'b0});
      tick();
      // MEM/WB for rs1, EX/MEM for rs2, b from imm; last legal op code
      set_exm(1'b1, 5'd4, 32'hCCCC, 1'b0);
      set_mwb(1'b1, 5'd8, 32'hBBBB);
      drive(1'b1, 32'h48, 5'd8, 32'h80, 5'd4, 32'h40, 32'h10, 4'b1010,
            1'b0, 1'b1, 5'd9, 1'b1, 1'b1);
      exp_q.push_back('{32'hBBBB, 32'h10, 32'hCCCC, 32'h48, 32'h10, 4'b1010, 5'd9, 1'b1, 1'b1, 1'b0});
      tick();

      // Load-use on rs2: one stall cycle, one bubble, then MEM/WB forward
      set_exm(1'b1, 5'd7, 32'h999, 1'b1);
      set_mwb(1'b0, 5'd0, 32'h0);
      drive(1'b1, 32'h4C, 5'd1, 32'h10, 5'd7, 32'hDEAD, 32'h0, 4'b0001,
            1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
      #1;
      chk("lu_in_ready_stall", {31'd0, in_ready}, 32'd0);
      tick();
      chk("lu_bubble", {31'd0, out_valid}, 32'd0);
      set_exm(1'b0, 5'd0, 32'h0, 1'b0);
      set_mwb(1'b1, 5'd7, 32'h55);
      #1;
      chk("lu_in_ready_release", {31'd0, in_ready}, 32'd1);
      exp_q.push_back('{32'h10, 32'h55, 32'h55, 32'h4C, 32'h0, 4'b0001, 5'd10, 1'b1, 1'b0, 1'b0});
      tick();

      // No stall when the loaded reg is rs1 but the pc is selected, or is x0
      set_mwb(1'b0, 5'd0, 32'h0);
      set_exm(1'b1, 5'd12, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 5'd12, 32'h0, 5'd13, 32'h0, 32'h0, 4'b0000,
            1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("noh_a_sel_pc", {31'd0, in_ready}, 32'd1);
      set_exm(1'b1, 5'd0, 32'h0, 1'b1);
      in_rs2_idx = 5'd0;
      #1;
      chk("noh_x0", {31'd0, in_ready}, 32'd1);
      tick();
      chk("drain_bubble", {31'd0, out_valid}, 32'd0);

      // Backpressure: output held for 3 cycles, then back-to-back transfer
      set_exm(1'b0, 5'd0, 32'h0, 1'b0);
      drive(1'b1, 32'h200, 5'd2, 32'h22, 5'd3, 32'h33, 32'h0, 4'b0010,
            1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
      exp_q.push_back('{32'h22, 32'h33, 32'h33, 32'h200, 32'h0, 4'b0010, 5'd5, 1'b1, 1'b0, 1'b0});
      tick();
      drive(1'b1, 32'h204, 5'd4, 32'h44, 5'd5, 32'h55, 32'h0, 4'b0011,
            1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_alu_a", alu_a, 32'h22);
         chk("bp_alu_b", alu_b, 32'h33);
         chk("bp_out_pc", out_pc, 32'h200);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back('{32'h44, 32'h55, 32'h55, 32'h204, 32'h0, 4'b0011, 5'd6, 1'b1, 1'b0, 1'b0});
      tick();
      in_valid = 1'b0;
      chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);
      chk("bp_next_alu_a", alu_a, 32'h44);
      tick();

      // Operand select with a reserved op code
      drive(1'b1, 32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 32'hFFFFFFFC, 4'b1100,
            1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
      exp_q.push_back('{32'h100, 32'hFFFFFFFC, 32'h22, 32'h100, 32'hFFFFFFFC, 4'b1100, 5'd1, 1'b1, 1'b0, 1'b1});
      tick();
      in_valid = 1'b0;
      tick();

      // Flush with a valid output and a stalled valid input
      drive(1'b1, 32'h300, 5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 4'b1111,
            1'b0, 1'b0, 5'd2, 1'b0, 1'b1);
      exp_q.push_back('{32'h3, 32'h4, 32'h4, 32'h300, 32'h0, 4'b1111, 5'd2, 1'b0, 1'b1, 1'b1});
      tick();
      set_exm(1'b1, 5'd9, 32'h0, 1'b1);
      drive(1'b1, 32'h304, 5'd9, 32'h9, 5'd9, 32'h9, 32'h0, 4'b0000,
            1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      set_exm(1'b0, 5'd0, 32'h0, 1'b0);
      chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_illegal", {31'd0, illegal_op}, 32'd0);
      tick();
      chk("fl_dropped", {31'd0, out_valid}, 32'd0);
      tick();
      tick();
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
